// File: rtl/dz_pkg.sv
// Shared constants, SILO word layout and scanner state encoding for the DZ-11 receive path.
package dz_pkg;

  localparam int NLINES      = 8;
  localparam int SILO_DEPTH  = 64;
  localparam int ALARM_LEVEL = 16;

  localparam int OERR     = 13;
  localparam int FERR     = 12;
  localparam int PERR     = 11;
  localparam int LINE_MSB = 10;
  localparam int LINE_LSB = 8;
  localparam int CHAR_MSB = 7;
  localparam int CHAR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ACK   = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic logic [13:0] make_word(input logic oerr, input logic ferr,
                                            input logic perr, input logic [2:0] line,
                                            input logic [7:0] ch);
    logic [13:0] w;
    w                    = '0;
    w[OERR]              = oerr;
    w[FERR]              = ferr;
    w[PERR]              = perr;
    w[LINE_MSB:LINE_LSB] = line;
    w[CHAR_MSB:CHAR_LSB] = ch;
    return w;
  endfunction

endpackage

// File: rtl/dz_rx_timer.sv
// SILO inactivity timer: raises a sticky tmo after TIMEOUT clken cycles with a partly
// filled SILO and no pushes or pops. Only instantiated when DZ_RXTIMER_EN is defined.
module dz_rx_timer #(
  parameter int TIMEOUT     = 4095,
  parameter int ALARM_LEVEL = dz_pkg::ALARM_LEVEL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       sae,
  input  logic [5:0] count,
  input  logic       wr_exit,
  input  logic       rd_done,
  output logic       tmo
);
  import dz_pkg::*;

  localparam logic [11:0] LIMIT     = 12'(TIMEOUT);
  localparam logic [5:0]  ALARM_CNT = 6'(ALARM_LEVEL);

  logic [11:0] timer;
  logic        clear;
  logic        inc;

  assign clear = wr_exit | rd_done | (count == 6'd0);
  assign inc   = clken & sae & ~clear & (count < ALARM_CNT) & (timer != LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      tmo   <= 1'b0;
    end else begin
      if (clear)    timer <= '0;
      else if (inc) timer <= timer + 12'd1;
      // tmo sets on the same edge the timer reaches the limit
      if (rd_done)                           tmo <= 1'b0;
      else if (inc && timer == LIMIT - 12'd1) tmo <= 1'b1;
    end
  end

endmodule

// File: rtl/dz_rx_scanner.sv
// DZ-11 receive scanner: round-robin UART scan into the 64-entry SILO, mirror occupancy
// count and receive interrupt. Optional inactivity timer interrupt under DZ_RXTIMER_EN.
module dz_rx_scanner #(
  parameter int ALARM_LEVEL = dz_pkg::ALARM_LEVEL,
  parameter int TIMEOUT     = 4095
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clken,
  input  logic                         clr,
  input  logic                         mse,
  input  logic                         sae,
  input  logic                         rie,
  input  logic [dz_pkg::NLINES-1:0]    uart_rfull,
  input  logic [8*dz_pkg::NLINES-1:0]  uart_rdata,
  input  logic [dz_pkg::NLINES-1:0]    uart_perr,
  input  logic [dz_pkg::NLINES-1:0]    uart_ferr,
  output logic [dz_pkg::NLINES-1:0]    uart_rack,
  output logic [13:0]                  fifo_din,
  output logic                         fifo_wr,
  output logic                         fifo_rd,
  input  logic                         fifo_empty,
  input  logic                         rbuf_rd,
  output logic [5:0]                   count,
  output logic                         rx_irq
);
  import dz_pkg::*;

  localparam logic [5:0] COUNT_MAX = 6'(SILO_DEPTH - 1);
  localparam logic [5:0] ALARM_CNT = 6'(ALARM_LEVEL);

  state_t            state;
  logic [2:0]        ptr;
  logic [NLINES-1:0] ovr;
  logic              last_rbuf_rd;
  logic              srst;
  logic              wr_exit;
  logic              rd_done;
  logic              silo_full;
  logic              irq_next;

  // Handshakes: uart_rack is a one-clk strobe on the clken cycle that leaves ACK;
  // fifo_wr is a level for the whole WRITE state and the SILO samples it only with
  // clken, so each word is pushed exactly once.
  assign srst      = rst | clr;
  assign fifo_wr   = (state == WRITE);
  assign fifo_rd   = rbuf_rd;
  assign wr_exit   = clken & fifo_wr;
  assign rd_done   = clken & last_rbuf_rd & ~rbuf_rd & (count != 6'd0);
  assign silo_full = (count == COUNT_MAX) | ((count == COUNT_MAX - 6'd1) & fifo_wr);
  assign uart_rack = (state == ACK && clken && !srst) ? (NLINES'(1) << ptr) : '0;

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      ptr      <= '0;
      ovr      <= '0;
      fifo_din <= '0;
    end else if (clken) begin
      case (state)
        IDLE: if (mse) state <= SCAN;
        SCAN: begin
          if (!mse)                 state <= IDLE;
          else if (uart_rfull[ptr]) state <= ACK;
          else                      ptr   <= ptr + 3'd1;
        end
        ACK: begin
          fifo_din <= make_word(ovr[ptr], uart_ferr[ptr], uart_perr[ptr], ptr,
                                uart_rdata[{ptr, 3'b000} +: 8]);
          // no room: the acknowledged char is dropped and the line remembers it
          if (silo_full) begin
            ovr[ptr] <= 1'b1;
            ptr      <= ptr + 3'd1;
            state    <= SCAN;
          end else begin
            state    <= WRITE;
          end
        end
        WRITE: begin
          ovr[ptr] <= 1'b0;
          ptr      <= ptr + 3'd1;
          state    <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    last_rbuf_rd <= rbuf_rd;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count <= '0;
    end else if (wr_exit && !rd_done) begin
      if (count != COUNT_MAX) count <= count + 6'd1;
    end else if (rd_done && !wr_exit) begin
      count <= count - 6'd1;
    end
  end

`ifdef DZ_RXTIMER_EN
  logic tmo;

  dz_rx_timer #(
    .TIMEOUT     (TIMEOUT),
    .ALARM_LEVEL (ALARM_LEVEL)
  ) u_timer (
    .clk     (clk),
    .rst     (srst),
    .clken   (clken),
    .sae     (sae),
    .count   (count),
    .wr_exit (wr_exit),
    .rd_done (rd_done),
    .tmo     (tmo)
  );

  assign irq_next = rie & ((sae ? (count >= ALARM_CNT) : ~fifo_empty) | tmo);
`else
  assign irq_next = rie & (sae ? (count >= ALARM_CNT) : ~fifo_empty);
`endif

  always_ff @(posedge clk) begin
    if (srst) rx_irq <= 1'b0;
    else      rx_irq <= irq_next;
  end

endmodule
